hazard_unit: RTL and testbench

- Pipeline hazard controller for the 5-stage MIPS core; sits beside the forwarding unit and covers the cases forwarding cannot resolve.
- Detects load-use and jr/jalr register hazards in ID.
- Tracks the multi-cycle multiply/divide unit with a busy FSM.
- Drives PC/IF-ID write enables, ID/EX bubble insertion, IF/ID flush, and a saturating stall-cycle performance counter.

---
 rtl/hazard_pkg.sv | 12 +
 rtl/hazard_unit_md_busy_tracker.sv | 67 ++++++
 rtl/hazard_unit.sv | 81 ++++++++
 tb/tb_hazard_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } mdState_t;

  localparam logic [4:0] REG_ZERO       = 5'd0;
  localparam int         MD_CYCLES_DEF  = 32;

endpackage

// File: rtl/hazard_unit_md_busy_tracker.sv
// Busy tracker for the multi-cycle mult/div unit: down-counter with a
// terminal-count compare, and a registered done pulse on normal completion.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   MD_IDLE | unit free, waiting for a start from EX
//   MD_BUSY | operation in flight, mdCnt counts down to 0
module md_busy_tracker
  import hazard_pkg::*;
#(
  parameter int MD_CYCLES = MD_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mdStart,
  output logic mdBusy,
  output logic mdDone
);

  localparam int CW = $clog2(MD_CYCLES);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MD_CYCLES - 1);

  mdState_t         state, stateNext;
  logic [CW-1:0]    mdCnt, mdCntNext;
  logic             mdDoneNext;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= MD_IDLE;
      mdCnt  <= '0;
      mdDone <= 1'b0;
    end else begin
      state  <= stateNext;
      mdCnt  <= mdCntNext;
      mdDone <= mdDoneNext;
    end
  end

  always_comb begin
    stateNext  = state;
    mdCntNext  = mdCnt;
    mdDoneNext = 1'b0;
    unique case (state)
      MD_IDLE: begin
        if (mdStart) begin
          stateNext = MD_BUSY;
          mdCntNext = CNT_LOAD;
        end
      end
      MD_BUSY: begin
        // A restart while busy abandons the old op without a done pulse.
        if (mdStart) begin
          mdCntNext = CNT_LOAD;
        end else if (mdCnt == '0) begin
          stateNext  = MD_IDLE;
          mdDoneNext = 1'b1;
        end else begin
          mdCntNext = mdCnt - CW'(1);
        end
      end
      default: stateNext = MD_IDLE;
    endcase
  end

  assign mdBusy = (state == MD_BUSY);

endmodule

// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage core: load-use, jr/jalr and hi/lo
// stalls, IF/ID flush on taken control flow, and a stall-cycle counter.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int MD_CYCLES = MD_CYCLES_DEF,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       Rs_ID,
  input  logic [4:0]       Rt_ID,
  input  logic             UseRt_ID,
  input  logic             Jr_ID,
  input  logic             HiLoUse_ID,
  input  logic             BranchTaken_ID,
  input  logic             Jump_ID,
  input  logic [4:0]       RegAddr_EX,
  input  logic             RegWrite_EX,
  input  logic             MemRead_EX,
  input  logic [4:0]       RegAddr_MEM,
  input  logic             MemRead_MEM,
  input  logic             MdStart_EX,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IDEXBubble,
  output logic             IFIDFlush,
  output logic             MdBusy,
  output logic             MdDone,
  output logic [CNT_W-1:0] StallCnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic loadUse, jrHazard, mdHazard, stall;

  md_busy_tracker #(.MD_CYCLES(MD_CYCLES)) u_mdTracker (
    .clk     (clk),
    .rst_n   (rst_n),
    .mdStart (MdStart_EX),
    .mdBusy  (MdBusy),
    .mdDone  (MdDone)
  );

  assign loadUse = MemRead_EX && (RegAddr_EX != REG_ZERO) &&
                   ((Rs_ID == RegAddr_EX) || (UseRt_ID && (Rt_ID == RegAddr_EX)));

  // ALU results in EX/MEM are forwarded to jr; only load data is too late.
  assign jrHazard = Jr_ID && (Rs_ID != REG_ZERO) &&
                    ((RegWrite_EX && MemRead_EX && (RegAddr_EX == Rs_ID)) ||
                     (MemRead_MEM && (RegAddr_MEM == Rs_ID)));

  assign mdHazard = HiLoUse_ID && (MdBusy || MdStart_EX);

  assign stall = loadUse || jrHazard || mdHazard;

  always_comb begin
    PCWrite    = 1'b1;
    IFIDWrite  = 1'b1;
    IDEXBubble = 1'b0;
    IFIDFlush  = 1'b0;
    if (rst_n) begin
      if (stall) begin
        PCWrite    = 1'b0;
        IFIDWrite  = 1'b0;
        IDEXBubble = 1'b1;
      end else begin
        IFIDFlush = BranchTaken_ID || Jump_ID;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      StallCnt <= '0;
    end else if (stall && (StallCnt != CNT_MAX)) begin
      StallCnt <= StallCnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit with MD_CYCLES=4 and CNT_W=2.
module tb_hazard_unit;

  localparam int MD_CYCLES = 4;
  localparam int CNT_W     = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [4:0]       Rs_ID, Rt_ID, RegAddr_EX, RegAddr_MEM;
  logic             UseRt_ID, Jr_ID, HiLoUse_ID, BranchTaken_ID, Jump_ID;
  logic             RegWrite_EX, MemRead_EX, MemRead_MEM, MdStart_EX;
  logic             PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, MdBusy, MdDone;
  logic [CNT_W-1:0] StallCnt;

  int nTests = 0;
  int nFail  = 0;

  hazard_unit #(.MD_CYCLES(MD_CYCLES), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .Rs_ID          (Rs_ID),
    .Rt_ID          (Rt_ID),
    .UseRt_ID       (UseRt_ID),
    .Jr_ID          (Jr_ID),
    .HiLoUse_ID     (HiLoUse_ID),
    .BranchTaken_ID (BranchTaken_ID),
    .Jump_ID        (Jump_ID),
    .RegAddr_EX     (RegAddr_EX),
    .RegWrite_EX    (RegWrite_EX),
    .MemRead_EX     (MemRead_EX),
    .RegAddr_MEM    (RegAddr_MEM),
    .MemRead_MEM    (MemRead_MEM),
    .MdStart_EX     (MdStart_EX),
    .PCWrite        (PCWrite),
    .IFIDWrite      (IFIDWrite),
    .IDEXBubble     (IDEXBubble),
    .IFIDFlush      (IFIDFlush),
    .MdBusy         (MdBusy),
    .MdDone         (MdDone),
    .StallCnt       (StallCnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearIn();
    Rs_ID = 5'd0; Rt_ID = 5'd0; RegAddr_EX = 5'd0; RegAddr_MEM = 5'd0;
    UseRt_ID = 1'b0; Jr_ID = 1'b0; HiLoUse_ID = 1'b0; BranchTaken_ID = 1'b0;
    Jump_ID = 1'b0; RegWrite_EX = 1'b0; MemRead_EX = 1'b0; MemRead_MEM = 1'b0;
    MdStart_EX = 1'b0;
  endtask

  task automatic doReset();
    clearIn();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    clearIn();
    rst_n = 1'b0;
    // Outputs are forced during reset even with a hazard present.
    MemRead_EX = 1'b1; RegAddr_EX = 5'd8; Rs_ID = 5'd8;
    #1;
    chk("rst_pcwrite", PCWrite, 1);
    chk("rst_ifidwrite", IFIDWrite, 1);
    chk("rst_bubble", IDEXBubble, 0);
    chk("rst_flush", IFIDFlush, 0);
    tick();
    tick();
    chk("rst_stallcnt", StallCnt, 0);
    chk("rst_mdbusy", MdBusy, 0);
    chk("rst_mddone", MdDone, 0);

    // Load-use on rs
    rst_n = 1'b1;
    #1;
    chk("lu_pcwrite", PCWrite, 0);
    chk("lu_ifidwrite", IFIDWrite, 0);
    chk("lu_bubble", IDEXBubble, 1);
    tick();
    chk("lu_stallcnt", StallCnt, 1);
    Rs_ID = 5'd0; RegAddr_EX = 5'd0;
    #1;
    chk("lu_r0_bubble", IDEXBubble, 0);
    chk("lu_r0_pcwrite", PCWrite, 1);
    Rt_ID = 5'd9; RegAddr_EX = 5'd9; UseRt_ID = 1'b1; Rs_ID = 5'd3;
    #1;
    chk("lu_rt_bubble", IDEXBubble, 1);
    UseRt_ID = 1'b0;
    #1;
    chk("lu_rt_unused", IDEXBubble, 0);

    // Load followed by jr: two stall cycles, then flush
    doReset();
    MemRead_EX = 1'b1; RegWrite_EX = 1'b1; RegAddr_EX = 5'd31;
    Jr_ID = 1'b1; Jump_ID = 1'b1; Rs_ID = 5'd31;
    #1;
    chk("ldjr_c1_bubble", IDEXBubble, 1);
    chk("ldjr_c1_flush", IFIDFlush, 0);
    tick();
    MemRead_EX = 1'b0; RegWrite_EX = 1'b0; RegAddr_EX = 5'd0;
    MemRead_MEM = 1'b1; RegAddr_MEM = 5'd31;
    #1;
    chk("ldjr_c2_bubble", IDEXBubble, 1);
    chk("ldjr_c2_pcwrite", PCWrite, 0);
    tick();
    MemRead_MEM = 1'b0; RegAddr_MEM = 5'd0;
    #1;
    chk("ldjr_c3_bubble", IDEXBubble, 0);
    chk("ldjr_c3_flush", IFIDFlush, 1);
    chk("ldjr_stallcnt", StallCnt, 2);

    // ALU producer feeding jr is forwarded
    clearIn();
    RegWrite_EX = 1'b1; RegAddr_EX = 5'd5; Rs_ID = 5'd5; Jr_ID = 1'b1; Jump_ID = 1'b1;
    #1;
    chk("alujr_bubble", IDEXBubble, 0);
    chk("alujr_flush", IFIDFlush, 1);
    clearIn();
    Jr_ID = 1'b1; MemRead_MEM = 1'b1; RegAddr_MEM = 5'd0; Rs_ID = 5'd0;
    #1;
    chk("jr_r0_bubble", IDEXBubble, 0);

    // Mult/div busy window and hi/lo stall; StallCnt saturates at 3
    doReset();
    HiLoUse_ID = 1'b1; MdStart_EX = 1'b1;
    #1;
    chk("md_c0_bubble", IDEXBubble, 1);
    chk("md_c0_busy", MdBusy, 0);
    tick();
    MdStart_EX = 1'b0;
    for (int c = 1; c <= MD_CYCLES; c++) begin
      #1;
      chk($sformatf("md_c%0d_busy", c), MdBusy, 1);
      chk($sformatf("md_c%0d_done", c), MdDone, 0);
      chk($sformatf("md_c%0d_bubble", c), IDEXBubble, 1);
      tick();
    end
    chk("md_c5_busy", MdBusy, 0);
    chk("md_c5_done", MdDone, 1);
    chk("md_c5_bubble", IDEXBubble, 0);
    chk("sat_stallcnt", StallCnt, 3);
    tick();
    chk("md_c6_done", MdDone, 0);
    chk("sat_hold", StallCnt, 3);

    // Stall beats branch flush
    doReset();
    MemRead_EX = 1'b1; RegAddr_EX = 5'd12; Rs_ID = 5'd12; BranchTaken_ID = 1'b1;
    #1;
    chk("prio_flush", IFIDFlush, 0);
    chk("prio_bubble", IDEXBubble, 1);
    tick();
    MemRead_EX = 1'b0;
    #1;
    chk("prio_next_flush", IFIDFlush, 1);
    chk("prio_next_bubble", IDEXBubble, 0);

    // Reset while busy aborts with no done pulse
    doReset();
    HiLoUse_ID = 1'b1; MdStart_EX = 1'b1;
    tick();
    MdStart_EX = 1'b0;
    #1;
    chk("rbusy_busy", MdBusy, 1);
    chk("rbusy_cnt1", StallCnt, 1);
    tick();
    chk("rbusy_cnt2", StallCnt, 2);
    rst_n = 1'b0;
    #1;
    chk("rbusy_forced_pc", PCWrite, 1);
    tick();
    chk("rbusy_abort_busy", MdBusy, 0);
    chk("rbusy_abort_done", MdDone, 0);
    chk("rbusy_abort_cnt", StallCnt, 0);
    rst_n = 1'b1; HiLoUse_ID = 1'b0;
    tick();
    chk("rbusy_after_done", MdDone, 0);
    chk("rbusy_after_busy", MdBusy, 0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
